psum_buf_sched: RTL

PSUM_BUF_SCHED -- requirements
Module: psum_buf_sched

---
 rtl/psum_pkg.sv | 15 +
 rtl/psum_buf_sched_if.sv | 35 +++
 rtl/psum_drain_fifo.sv | 49 ++++
 rtl/psum_buf_sched.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared accelerator package: scheduler FSM encoding and drain FIFO depth.
// Imported by the psum buffer scheduler and its drain FIFO.
package psum_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_FLUSH = 3'd4
    } psum_state_e;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/psum_buf_sched_if.sv
// Psum buffer memory port and drain stream bundles.
// master = scheduler side, slave = memory / consumer side.
interface psum_buf_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wadd;
    logic                  wren;
    logic [DATA_WIDTH-1:0] idat;
    logic [ADDR_WIDTH-1:0] radd;
    logic                  rden;
    logic [DATA_WIDTH-1:0] odat;
    logic                  ovld;

    modport master (
        output wadd, wren, idat, radd, rden,
        input  odat, ovld
    );
    modport slave (
        input  wadd, wren, idat, radd, rden,
        output odat, ovld
    );
endinterface

interface psum_drn_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] dat;
    logic                  vld;
    logic                  last;
    logic                  rdy;

    modport master (output dat, vld, last, input rdy);
    modport slave  (input dat, vld, last, output rdy);
endinterface

// File: rtl/psum_drain_fifo.sv
// Two-entry drain FIFO between buffer read returns and the drain stream.
// Push on a full FIFO is dropped; the scheduler's read credit prevents it.
module psum_drain_fifo
    import psum_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic [1:0]       cnt
);
    logic [WIDTH-1:0] slot_q [FIFO_DEPTH];
    logic             wp_q;
    logic             rp_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign vld     = cnt_q != 2'd0;
    assign do_push = push && (cnt_q != 2'(FIFO_DEPTH));
    assign do_pop  = pop && vld;
    assign dout    = slot_q[rp_q];
    assign cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) slot_q[wp_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) wp_q <= ~wp_q;
            if (do_pop)  rp_q <= ~rp_q;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/psum_buf_sched.sv
// Psum buffer scheduler: clear, accumulate pass-through, ordered drain.
// Define PSUM_BUF_SCHED_CLEAR_EN to build the CLEAR state.
module psum_buf_sched
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [REG_WIDTH-1:0]  i_conf_bufdepth,
    input  logic [ADDR_WIDTH-1:0] acc_radd,
    input  logic                  acc_rden,
    input  logic [ADDR_WIDTH-1:0] acc_wadd,
    input  logic                  acc_wren,
    input  logic [DATA_WIDTH-1:0] acc_idat,
    output logic [DATA_WIDTH-1:0] acc_odat,
    output logic                  acc_ovld,
    input  logic                  acc_done,
    psum_buf_sched_if.master      mem,
    psum_drn_if.master            drn,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_state
);
    psum_state_e           state_q;
    psum_state_e           state_d;
    logic [REG_WIDTH-1:0]  n_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  at_last;
    logic                  rd_pend_q;
    logic                  last_pend_q;
    logic                  done_q;
    logic [1:0]            fifo_cnt;
    logic [2:0]            in_flight;
    logic                  can_issue;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_vld;
    logic [DATA_WIDTH:0]   fifo_head;

    assign last_addr = ADDR_WIDTH'(n_q - REG_WIDTH'(1));
    assign at_last   = cnt_q == last_addr;
    assign in_flight = {1'b0, fifo_cnt} + {2'b00, rd_pend_q};
    assign can_issue = in_flight < 3'(FIFO_DEPTH);
    // Returns only count when we asked for them; stray ovld after reset is dropped.
    assign fifo_push = mem.ovld & rd_pend_q;
    assign fifo_pop  = fifo_vld & drn.rdy;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start && i_conf_bufdepth != '0)
`ifdef PSUM_BUF_SCHED_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_ACCUM;
`endif
            end
            S_CLEAR: if (at_last) state_d = S_ACCUM;
            S_ACCUM: if (acc_done && !acc_wren) state_d = S_DRAIN;
            S_DRAIN: if (can_issue && at_last) state_d = S_FLUSH;
            S_FLUSH: if (fifo_cnt == 2'd0 && !rd_pend_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem.wadd = '0;
        mem.wren = 1'b0;
        mem.idat = '0;
        mem.radd = '0;
        mem.rden = 1'b0;
        acc_odat = '0;
        acc_ovld = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                mem.wren = 1'b1;
                mem.wadd = cnt_q;
            end
            S_ACCUM: begin
                mem.wadd = acc_wadd;
                mem.wren = acc_wren;
                mem.idat = acc_idat;
                mem.radd = acc_radd;
                mem.rden = acc_rden;
                acc_odat = mem.odat;
                acc_ovld = mem.ovld;
            end
            S_DRAIN: begin
                mem.rden = can_issue;
                mem.radd = cnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            last_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_pend_q   <= mem.rden && state_q == S_DRAIN;
            last_pend_q <= mem.rden && state_q == S_DRAIN && at_last;
            done_q      <= (state_q == S_IDLE && i_start &&
                            i_conf_bufdepth == '0) ||
                           (state_q == S_FLUSH && state_d == S_IDLE);
            if (state_q == S_IDLE && i_start) n_q <= i_conf_bufdepth;
            if (state_d != state_q &&
                (state_d == S_CLEAR || state_d == S_DRAIN))
                cnt_q <= '0;
            else if ((state_q == S_CLEAR) ||
                     (state_q == S_DRAIN && mem.rden))
                cnt_q <= cnt_q + ADDR_WIDTH'(1);
        end
    end

    psum_drain_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .din  ({last_pend_q, mem.odat}),
        .pop  (fifo_pop),
        .dout (fifo_head),
        .vld  (fifo_vld),
        .cnt  (fifo_cnt)
    );

    assign drn.vld  = fifo_vld;
    assign drn.dat  = fifo_head[DATA_WIDTH-1:0];
    assign drn.last = fifo_vld & fifo_head[DATA_WIDTH];
    assign o_busy   = state_q != S_IDLE;
    assign o_done   = done_q;
    assign o_state  = state_q;
endmodule
